score_neighbor_fetch: RTL

- Parametrised successor to the score-RAM read-index logic of the Needleman-Wunsch datapath.
- Accepts a target cell request and issues the three neighbour reads (diag, up, left) to the score RAM on its own.
- Handles a configurable RAM read latency, captures the returned scores, and presents all three together with a valid/ready handshake to the cell-compute stage.
- Supports rectangular (N+1)x(M+1) matrices in row-major order, row stride M+1.

---
 rtl/score_neighbor_fetch.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/score_neighbor_fetch.sv
// score_neighbor_fetch: issues the diag/up/left score-RAM reads for one
// Needleman-Wunsch cell and presents the three neighbour scores together.
// The optional macro SKIP_BOUNDARY_EN suppresses reads of row-0/column-0
// neighbours and substitutes their linear-gap boundary value instead.
module score_neighbor_fetch #(
    parameter int unsigned N       = 128,
    parameter int unsigned M       = 128,
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned GAP     = 2,
    parameter int unsigned IDX_W   = $clog2((N + 1 > M + 1) ? N + 1 : M + 1),
    parameter int unsigned ADDR_W  = $clog2((N + 1) * (M + 1))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [IDX_W-1:0]   i,
    input  logic [IDX_W-1:0]   j,
    output logic               ram_rd_en,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [SCORE_W-1:0] ram_rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SCORE_W-1:0] diag_score,
    output logic [SCORE_W-1:0] up_score,
    output logic [SCORE_W-1:0] left_score,
    output logic [IDX_W-1:0]   out_i,
    output logic [IDX_W-1:0]   out_j,
    output logic               err_range
);

    localparam logic [ADDR_W-1:0]  RowStride = ADDR_W'(M + 1);
    localparam logic [IDX_W-1:0]   NIdx      = IDX_W'(N);
    localparam logic [IDX_W-1:0]   MIdx      = IDX_W'(M);
    localparam logic [SCORE_W-1:0] GapW      = SCORE_W'(GAP);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

    state_e              state_q;
    logic [1:0]          slot_q;
    logic [IDX_W-1:0]    i_q, j_q;
    logic [ADDR_W-1:0]   base_q, last_addr_q;
    logic                err_q, out_valid_q;
    logic [SCORE_W-1:0]  diag_q, up_q, left_q;

    // Tag pipeline: one entry per read slot, aligned with the returning RAM data
    logic [RD_LAT-1:0]       tag_vld_q, tag_skip_q;
    logic [RD_LAT-1:0][1:0]  tag_id_q;

    logic                cap_vld, cap_skip;
    logic [1:0]          cap_id;
    logic                issue, skip_cur;
    logic                skip_diag, skip_up, skip_left;
    logic [ADDR_W-1:0]   addr_calc;
    logic [SCORE_W-1:0]  bnd_diag, bnd_up, bnd_left;

`ifdef SKIP_BOUNDARY_EN
    assign skip_diag = (i_q == '0) || (j_q == '0);
    assign skip_up   = (i_q == '0);
    assign skip_left = (j_q == '0);
`else
    assign skip_diag = 1'b0;
    assign skip_up   = 1'b0;
    assign skip_left = 1'b0;
`endif

    // Boundary scores of a linear-gap matrix: cell (r,0) or (0,c) is -(r+c)*GAP
    assign bnd_diag = (i_q == '0) ? -(SCORE_W'(j_q) * GapW) : -(SCORE_W'(i_q) * GapW);
    assign bnd_up   = -((SCORE_W'(j_q) + SCORE_W'(1)) * GapW);
    assign bnd_left = -((SCORE_W'(i_q) + SCORE_W'(1)) * GapW);

    assign issue    = (state_q == StIssue);
    assign cap_vld  = tag_vld_q[RD_LAT-1];
    assign cap_id   = tag_id_q[RD_LAT-1];
    assign cap_skip = tag_skip_q[RD_LAT-1];

    // Slot address from the registered row base; no multiplier in this path
    always_comb begin
        addr_calc = base_q + ADDR_W'(j_q);
        skip_cur  = skip_diag;
        case (slot_q)
            2'd1: begin
                addr_calc = base_q + ADDR_W'(j_q) + ADDR_W'(1);
                skip_cur  = skip_up;
            end
            2'd2: begin
                addr_calc = base_q + RowStride + ADDR_W'(j_q);
                skip_cur  = skip_left;
            end
            default: ;
        endcase
    end

    assign ram_rd_en = issue && !skip_cur;
    assign ram_addr  = ram_rd_en ? addr_calc : last_addr_q;

    // Request FSM: accept, three issue slots, wait for last return, hold result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            base_q      <= '0;
            last_addr_q <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (ram_rd_en) begin
                last_addr_q <= ram_addr;
            end
            case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        i_q    <= i;
                        j_q    <= j;
                        base_q <= ADDR_W'(i) * RowStride;
                        if (i >= NIdx || j >= MIdx) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= StIssue;
                            slot_q  <= '0;
                        end
                    end
                end
                StIssue: begin
                    if (slot_q == 2'd2) begin
                        state_q <= StWait;
                        slot_q  <= '0;
                    end else begin
                        slot_q <= slot_q + 2'd1;
                    end
                end
                StWait: begin
                    if (cap_vld && cap_id == 2'd2) begin
                        state_q     <= StHold;
                        out_valid_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Shift slot tags alongside the RAM latency and capture each returning score
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q  <= '0;
            tag_skip_q <= '0;
            tag_id_q   <= '0;
            diag_q     <= '0;
            up_q       <= '0;
            left_q     <= '0;
        end else begin
            tag_vld_q[0]  <= issue;
            tag_skip_q[0] <= skip_cur;
            tag_id_q[0]   <= slot_q;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                tag_vld_q[k]  <= tag_vld_q[k-1];
                tag_skip_q[k] <= tag_skip_q[k-1];
                tag_id_q[k]   <= tag_id_q[k-1];
            end
            if (cap_vld) begin
                case (cap_id)
                    2'd0:    diag_q <= cap_skip ? bnd_diag : ram_rd_data;
                    2'd1:    up_q   <= cap_skip ? bnd_up   : ram_rd_data;
                    default: left_q <= cap_skip ? bnd_left : ram_rd_data;
                endcase
            end
        end
    end

    assign start_ready = (state_q == StIdle);
    assign out_valid   = out_valid_q;
    assign err_range   = err_q;
    assign diag_score  = diag_q;
    assign up_score    = up_q;
    assign left_score  = left_q;
    assign out_i       = i_q;
    assign out_j       = j_q;

endmodule
